// File: rtl/quick_spi_pkg.sv
// Shared types and constants for the quick_spi family.
//   state_t      : responder frame state (IDLE, ACTIVE)
//   spi_mode_t   : {cpol, cpha} pair; MODE0..MODE3 are the four SPI modes
//   FILL_DEFAULT : all-ones word shifted out when nothing was queued
package quick_spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

    localparam logic [63:0] FILL_DEFAULT = '1;

endpackage

// File: rtl/quick_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with edge pulses.
//   clk, reset_n : system clock, synchronous active-low reset
//   d            : asynchronous pin
//   q            : synchronized level (last synchronizer stage)
//   rise, fall   : one-cycle pulses when q differs from its previous value
// Parameters: SYNC_STAGES (>= 2), RESET_VAL (level assumed while in reset,
// so no false edge appears when reset is released with the pin idle).
module quick_spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_p;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p <= {SYNC_STAGES{RESET_VAL}};
            prev_p <= RESET_VAL;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign q    = sync_p[SYNC_STAGES-1];
    assign rise = q & ~prev_p;
    assign fall = ~q & prev_p;

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder for a single chip-select line, oversampling sclk/ss_n/mosi
// in the clk domain (clk must be at least 4x sclk).
//   clk, reset_n    : system clock, synchronous active-low reset
//   enable          : block enable; low forces IDLE
//   sclk, ss_n, mosi: asynchronous SPI pins
//   miso, miso_oe   : serial data out and its pad drive enable
//   busy            : frame active
//   incoming_data   : last complete received word
//   incoming_valid  : one-cycle pulse when incoming_data updates
//   outgoing_data   : word to transmit
//   outgoing_load   : captures outgoing_data when outgoing_ready is high
//   outgoing_ready  : transmit buffer empty
//   tx_underrun     : (only with QUICK_SPI_SLAVE_UNDERRUN_EN) pulses when a
//                     word starts with an empty buffer and FILL_VALUE goes out
// Optional feature macro: QUICK_SPI_SLAVE_UNDERRUN_EN
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic                  CPOL        = 1'b0,
    parameter logic                  CPHA        = 1'b0,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = FILL_DEFAULT[DATA_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] incoming_data,
    output logic                  incoming_valid,
    input  logic [DATA_WIDTH-1:0] outgoing_data,
    input  logic                  outgoing_load,
`ifdef QUICK_SPI_SLAVE_UNDERRUN_EN
    output logic                  tx_underrun,
`endif
    output logic                  outgoing_ready
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_n_s, ss_rise, ss_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_p;

    logic sclk_edge, leading, trailing, sample_edge, shift_edge;
    logic start, stop, word_end, consume, load_acc;
    logic [DATA_WIDTH-1:0] next_word;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  rx_done;

    // ---- input synchronizers ----
    quick_spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (CPOL)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk),
        .q       (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    quick_spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_ss_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ss_n),
        .q       (ss_n_s),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    // mosi travels through the same depth as sclk so data and edge stay aligned
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_sync_p <= '0;
        end else begin
            mosi_sync_p <= {mosi_sync_p[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_p[SYNC_STAGES-1];

    // ---- edge classification ----
    // The synchronized level after an edge tells whether sclk left or
    // returned to its idle (CPOL) level.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign leading     = sclk_edge && (sclk_s != CPOL);
    assign trailing    = sclk_edge && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading  : trailing;

    // ss_n edge pulses coincide with the level change, so these reduce to
    // the synchronized chip-select level.
    assign start = enable && (!ss_n_s || ss_fall);
    assign stop  = !enable || ss_n_s || ss_rise;

    assign word_end  = (state == ACTIVE) && !stop && sample_edge && (bit_cnt == LAST_BIT);
    assign consume   = ((state == IDLE) && start) || word_end;
    assign load_acc  = outgoing_load && outgoing_ready;
    assign next_word = outgoing_ready ? FILL_VALUE : tx_buf;

    // ---- transmit buffer ----
    // A load and a consume in the same cycle: the shifter takes the old
    // contents (next_word) while the new word lands in the buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_buf         <= '0;
            outgoing_ready <= 1'b1;
        end else begin
            if (load_acc) begin
                tx_buf <= outgoing_data;
            end
            if (consume) begin
                outgoing_ready <= !load_acc;
            end else if (load_acc) begin
                outgoing_ready <= 1'b0;
            end
        end
    end

`ifdef QUICK_SPI_SLAVE_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= consume && outgoing_ready;
        end
    end
`endif

    // ---- receive word delivery (one cycle after the last sample edge) ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            incoming_data  <= '0;
            incoming_valid <= 1'b0;
        end else begin
            incoming_valid <= rx_done;
            if (rx_done) begin
                incoming_data <= rx_shift;
            end
        end
    end

    // ---- frame state machine ----
    // With CPHA=0 miso always mirrors tx_shift[MSB]; with CPHA=1 tx_shift[MSB]
    // is the bit to present at the next leading edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rx_done  <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (start) begin
                        state    <= ACTIVE;
                        tx_shift <= next_word;
                        busy     <= 1'b1;
                        miso_oe  <= 1'b1;
                        miso     <= CPHA ? 1'b0 : next_word[DATA_WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            rx_done  <= 1'b1;
                            tx_shift <= next_word;
                            if (!CPHA) begin
                                miso <= next_word[DATA_WIDTH-1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shift_edge) begin
                        if (CPHA) begin
                            miso     <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= tx_shift << 1;
                        end else if (bit_cnt != '0) begin
                            // A trailing edge with no sample yet in this word
                            // would skip the MSB, so it is ignored.
                            miso     <= tx_shift[DATA_WIDTH-2];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
